uart_module_rx: RTL and testbench

UART_MODULE_RX -- requirements
Module: uart_module_rx

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_sync.sv | 14 +
 rtl/uart_module_rx.sv | 101 ++++++++++
 tb/tb_uart_module_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud constants, data width and RX state encoding.
package uart_pkg;
  localparam int D1_CNT_VALUE = 103;
  localparam int D1_CNT_HALF  = 51;
  localparam int DATA_W       = 8;
  localparam int CNT_W        = 7;
  localparam int IDX_W        = 4;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line.
// Ports: clk1mhz clock, reset async active-low (flops reset to 1 = line idle),
//        d async input, q synchronized output.
module uart_rx_sync (
  input  logic clk1mhz,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk1mhz or negedge reset)
    if (!reset) {q, s1} <= 2'b11;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_module_rx.sv
// uart_module_rx: 8N1 UART receiver with ready/ack handshake, overrun and framing error.
// Ports: clk1mhz clock, reset async active-low, rxd serial in (idle high),
//        rx_ack consumer ack, rx_data last good byte, rx_ready byte held,
//        overrun sticky lost-byte flag, frame_err one-cycle bad-stop pulse, busy not idle.
module uart_module_rx
  import uart_pkg::*;
#(
  parameter int D1_CNT_VALUE = uart_pkg::D1_CNT_VALUE,
  parameter int D1_CNT_HALF  = uart_pkg::D1_CNT_HALF
) (
  input  logic        clk1mhz,
  input  logic        reset,
  input  logic        rxd,
  input  logic        rx_ack,
  output logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(D1_CNT_VALUE);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(D1_CNT_HALF);
  rx_state_t          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DATA_W-1:0]  sh, sh_n, data_n;
  logic               rxd_s, ready_n, ovr_n, fe_n;
  uart_rx_sync u_sync (
    .clk1mhz (clk1mhz),
    .reset   (reset),
    .d       (rxd),
    .q       (rxd_s)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk1mhz or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_ready  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      rx_data   <= data_n;
      rx_ready  <= ready_n;
      overrun   <= ovr_n;
      frame_err <= fe_n;
    end
  // Ack clears ready/overrun by default; a good stop bit in the same cycle
  // re-asserts ready, and flags overrun only when an unacked byte is lost.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = rx_data;
    ready_n = rx_ready & ~rx_ack;
    ovr_n   = overrun & ~rx_ack;
    fe_n    = 1'b0;
    case (state)
      IDLE:
        if (!rxd_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      START:
        if (cnt == CNT_MID) begin
          state_n = rxd_s ? IDLE : DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end else cnt_n = cnt + 1'b1;
      DATA:
        if (cnt == CNT_END) begin
          cnt_n   = '0;
          sh_n    = {rxd_s, sh[DATA_W-1:1]};
          idx_n   = idx + 1'b1;
          state_n = (idx == IDX_W'(DATA_W - 1)) ? STOP : DATA;
        end else cnt_n = cnt + 1'b1;
      STOP:
        if (cnt == CNT_END) begin
          cnt_n   = '0;
          state_n = rxd_s ? IDLE : BREAK;
          fe_n    = ~rxd_s;
          if (rxd_s) begin
            data_n  = sh;
            ready_n = 1'b1;
            ovr_n   = ovr_n | (rx_ready & ~rx_ack);
          end
        end else cnt_n = cnt + 1'b1;
      BREAK:
        if (rxd_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_module_rx.sv
// tb_uart_module_rx: scoreboard-driven self-checking bench for uart_module_rx.
`timescale 1ns/1ps
module tb_uart_module_rx;
  logic       clk1mhz = 1'b0, reset = 1'b0, rxd = 1'b1, rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, overrun, frame_err, busy;
  int         n_cmp = 0, n_bad = 0, fe_cnt = 0, lat = 991;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  uart_module_rx dut (
    .clk1mhz   (clk1mhz),
    .reset     (reset),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );
  always #5 clk1mhz = ~clk1mhz;
  always @(negedge clk1mhz) if (frame_err === 1'b1) fe_cnt++;
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    rxd = 1'b0;
    repeat (104) @(negedge clk1mhz);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (104) @(negedge clk1mhz);
    end
    rxd = stop;
    repeat (104) @(negedge clk1mhz);
  endtask
  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk1mhz);
    rx_ack = 1'b0;
    @(negedge clk1mhz);
  endtask
  task automatic test_reset();
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", rx_ready); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk1mhz);
    reset = 1'b1;
    repeat (10) @(negedge clk1mhz);
  endtask
  task automatic test_basic();
    int cyc = 0;
    logic prev_busy = 1'b0, busy_at = 1'b1;
    fork
      send_frame(8'h35, 1'b1);
      begin
        while (cyc < 1100) begin
          prev_busy = busy;
          @(negedge clk1mhz);
          cyc++;
          if (rx_ready === 1'b1) begin busy_at = busy; break; end
        end
      end
    join
    lat = cyc;
    n_cmp++; if (cyc < 990 || cyc > 991) begin n_bad++; $display("FAIL basic_latency: got %0d want 990..991", cyc); end
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL basic_data: got %h want %h", rx_data, e); end
    n_cmp++; if (fe_cnt !== 0) begin n_bad++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_cnt); end
    n_cmp++; if (busy_at !== 1'b0 || prev_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_fall: got prev=%b now=%b want 1/0", prev_busy, busy_at); end
    pulse_ack();
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ack: got ready %b want 0", rx_ready); end
  endtask
  task automatic test_overrun();
    send_frame(8'h41, 1'b1);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== e || rx_ready !== 1'b1 || overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_first: got %h/%b/%b want %h/1/0", rx_data, rx_ready, overrun, e); end
    send_frame(8'hA5, 1'b1);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL ovr_data: got %h want %h", rx_data, e); end
    n_cmp++; if (overrun !== 1'b1 || rx_ready !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got ovr=%b rdy=%b want 1/1", overrun, rx_ready); end
    pulse_ack();
    n_cmp++; if (overrun !== 1'b0 || rx_ready !== 1'b0) begin n_bad++; $display("FAIL ovr_ack: got ovr=%b rdy=%b want 0/0", overrun, rx_ready); end
    pulse_ack();
    n_cmp++; if (overrun !== 1'b0 || rx_ready !== 1'b0 || rx_data !== 8'hA5) begin n_bad++; $display("FAIL idle_ack: got %b/%b/%h want 0/0/a5", overrun, rx_ready, rx_data); end
  endtask
  task automatic test_glitch();
    int fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (20) @(negedge clk1mhz);
    rxd = 1'b1;
    repeat (10) @(negedge clk1mhz);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_start: got busy %b want 1", busy); end
    repeat (60) @(negedge clk1mhz);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got busy %b want 0", busy); end
    n_cmp++; if (rx_ready !== 1'b0 || rx_data !== 8'hA5 || fe_cnt !== fe0) begin n_bad++; $display("FAIL glitch_flags: got %b/%h/%0d want 0/a5/%0d", rx_ready, rx_data, fe_cnt, fe0); end
  endtask
  task automatic test_break();
    int fe0 = fe_cnt;
    send_frame(8'h00, 1'b0);
    repeat (500) @(negedge clk1mhz);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL break_pulses: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (busy !== 1'b1 || rx_ready !== 1'b0 || rx_data !== 8'hA5) begin n_bad++; $display("FAIL break_hold: got %b/%b/%h want 1/0/a5", busy, rx_ready, rx_data); end
    rxd = 1'b1;
    repeat (10) @(negedge clk1mhz);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL break_exit: got busy %b want 0", busy); end
    send_frame(8'h5A, 1'b1);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== e || rx_ready !== 1'b1) begin n_bad++; $display("FAIL break_next: got %h/%b want %h/1", rx_data, rx_ready, e); end
  endtask
  task automatic test_reset_mid();
    rxd = 1'b0;
    repeat (104) @(negedge clk1mhz);
    rxd = 1'b1;
    repeat (4 * 104 + 50) @(negedge clk1mhz);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00 || rx_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_data: got %h/%b want 00/0", rx_data, rx_ready); end
    n_cmp++; if (overrun !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got %b/%b/%b want 0/0/0", overrun, frame_err, busy); end
    @(negedge clk1mhz);
    reset = 1'b1;
    repeat (20) @(negedge clk1mhz);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_after: got busy %b want 0", busy); end
    send_frame(8'h3C, 1'b1);
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== e || rx_ready !== 1'b1 || overrun !== 1'b0) begin n_bad++; $display("FAIL mid_next: got %h/%b/%b want %h/1/0", rx_data, rx_ready, overrun, e); end
  endtask
  task automatic test_ack_same();
    fork
      send_frame(8'h7E, 1'b1);
      begin
        for (int k = 1; k <= lat + 5; k++) begin
          @(negedge clk1mhz);
          if (k == lat - 1) rx_ack = 1'b1;
          if (k == lat) rx_ack = 1'b0;
        end
      end
    join
    e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL same_data: got %h want %h", rx_data, e); end
    n_cmp++; if (rx_ready !== 1'b1 || overrun !== 1'b0) begin n_bad++; $display("FAIL same_flags: got rdy=%b ovr=%b want 1/0", rx_ready, overrun); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_break();
    test_reset_mid();
    test_ack_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
